zx_ps2_keymatrix: RTL and testbench
===================================

Name: zx_ps2_keymatrix

Overview:
Upstream feeder for the port-FE keyboard read path. Receives PS/2 scan-code set 2 from a physical keyboard and maintains the 8x5 ZX Spectrum key matrix (active-low). Returns the 5 column bits for the row(s) selected by A15..A8, with zero latency. The IO block drives these bits onto D4..D0 during IN (FE), replacing the single-button ENTER path.

Parameters:
FILTER_LEN, 8, consecutive equal samples required before filtered ps2_clk changes level
TIMEOUT_CYC, 27000, idle clk cycles mid-frame before the receiver aborts the frame (~1 ms at 27 MHz)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset
ps2_clk  in  1  PS/2 clock from pad, asynchronous
ps2_data  in  1  PS/2 data from pad, asynchronous
addr_hi  in  8  CPU A15..A8; a 0 bit selects that row
keys_n  out  5  column bits D4..D0; 0 = a key in a selected row is pressed
scan_code  out  8  last valid received byte
scan_strobe  out  1  one-clk pulse when scan_code is updated
frame_err  out  1  one-clk pulse on parity, stop or timeout error

Behaviour:
- Reset (reset=0 at posedge clk): all 40 matrix bits =1; scan_code=8'h00; scan_strobe=0; frame_err=0; receiver IDLE; brk=0; ext=0.
- Input sync: 2-FF synchronisers on ps2_clk and ps2_data. Filtered clock changes only after FILTER_LEN identical synced samples. A filtered 1->0 transition is a "bit edge"; ps2_data is sampled at that edge.
- Receiver FSM:
  - IDLE: on a bit edge, data=0 -> DATA with bit count 0; data=1 -> stay in IDLE (spurious edge).
  - DATA: 8 edges, LSB first, then -> PARITY.
  - PARITY: sample parity bit; it must make the total count of 1s odd. -> STOP.
  - STOP: data=1 and parity ok -> byte valid. Otherwise pulse frame_err and discard. Either way -> IDLE.
  - Timeout: in any non-IDLE state, a timeout counter reaching TIMEOUT_CYC with no bit edge -> IDLE and pulse frame_err. The counter clears on every bit edge.
- Byte valid: scan_code loads and scan_strobe pulses in the clk after the stop-bit edge. The matrix and flags update in the same clk.
- Decoder, applied to each valid byte:
  - F0: set brk.
  - E0: set ext.
  - AA (BAT ok): all matrix bits ->1; clear flags.
  - Mapped code: target bit(s) <- brk (1 = released, 0 = pressed); clear flags.
  - Unmapped code, or ext=1 with the feature off: no matrix change; clear flags.
- Matrix rows (col0..col4):
  - r0 A8: CS Z X C V
  - r1 A9: A S D F G
  - r2 A10: Q W E R T
  - r3 A11: 1 2 3 4 5
  - r4 A12: 0 9 8 7 6
  - r5 A13: P O I U Y
  - r6 A14: ENTER L K J H
  - r7 A15: SPACE SS M N B
- Scan-code mapping:
  - Left shift 12 and right shift 59 -> CS.
  - Left ctrl 14 -> SS.
  - Enter 5A -> r6c0.
  - Space 29 -> r7c0.
  - Letters and digits use standard set-2 codes, e.g. 1C=A, 16=1, 45=0.
- Readout (combinational from registers): keys_n[c] = AND over all r with addr_hi[r]==0 of matrix[r][c]. addr_hi=FF -> 5'h1F. Multiple zero bits AND the selected rows.
- Shared bits: composite keys share bits (e.g. CS); the last event wins. No reference counting.
- Reset mid-frame: the partial byte is discarded and the matrix is cleared.

Optional Feature:
ZX_KBD_EXT_KEYS_EN
- Defined: E0-prefixed cursor keys map to two bits each: E0 6B left = CS+5, E0 72 down = CS+6, E0 75 up = CS+7, E0 74 right = CS+8. Backspace 66 (no prefix) = CS+0. Press clears both bits; release sets both.
- Undefined: every E0-prefixed code is ignored, and 66 is unmapped.

Decomposition:
- Package zx_kbd_pkg holds:
  - row/col index constants
  - scan-code constants: F0, E0, AA, 12, 59, 14, 5A, 29, cursor codes
  - the scan-code -> {valid, row[2:0], col[2:0]} lookup function
- Sub-module zx_ps2_rx: sync, filter, receiver FSM and timeout. Outputs rx_byte, rx_valid, rx_err.
- The top level holds the decoder flags, the matrix registers and the readout.

Test Plan:
- Send 5A, addr_hi=BF -> keys_n=5'h1E; scan_strobe pulses once per byte. Send F0 5A -> keys_n=5'h1F.
- Send 12 and 1A (Z), addr_hi=FE -> keys_n=5'h1C. Then addr_hi=00 -> 5'h1C. Then addr_hi=FF -> 5'h1F.
- Send byte 5A with wrong parity -> frame_err pulse, scan_strobe stays 0, matrix unchanged.
- Send 5 bits then hold ps2_clk high for TIMEOUT_CYC+10 cycles -> frame_err pulse. A following clean 29 frame is accepted: addr_hi=7F gives keys_n=5'h1E.
- Press A (1C), then send AA -> all rows read 5'h1F. Pull reset low mid-frame -> outputs return to reset values and the next frame decodes correctly.
- Send E0 75: with ZX_KBD_EXT_KEYS_EN, addr_hi=EF gives 5'h17 (col3 = 7) and addr_hi=FE gives 5'h1E. Without the macro, all rows read 5'h1F.

Source files
------------

// File: rtl/zx_kbd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : zx_kbd_pkg
//  Description : Shared constants for the PS/2 -> ZX Spectrum key matrix
//                path: row/column indices, set-2 scan codes and the
//                scan-code -> matrix position lookup functions.
//  Revision    : 1.0  initial release
// ============================================================================
package zx_kbd_pkg;

    // Matrix geometry
    localparam int c_NUM_ROWS = 8;
    localparam int c_NUM_COLS = 5;

    // Row indices (row r is selected by A(8+r) = 0)
    localparam logic [2:0] c_ROW_A8  = 3'd0;
    localparam logic [2:0] c_ROW_A9  = 3'd1;
    localparam logic [2:0] c_ROW_A10 = 3'd2;
    localparam logic [2:0] c_ROW_A11 = 3'd3;
    localparam logic [2:0] c_ROW_A12 = 3'd4;
    localparam logic [2:0] c_ROW_A13 = 3'd5;
    localparam logic [2:0] c_ROW_A14 = 3'd6;
    localparam logic [2:0] c_ROW_A15 = 3'd7;

    // Column indices (D0..D4)
    localparam logic [2:0] c_COL0 = 3'd0;
    localparam logic [2:0] c_COL1 = 3'd1;
    localparam logic [2:0] c_COL2 = 3'd2;
    localparam logic [2:0] c_COL3 = 3'd3;
    localparam logic [2:0] c_COL4 = 3'd4;

    // Scan-code set 2 constants
    localparam logic [7:0] c_SC_BREAK  = 8'hF0;
    localparam logic [7:0] c_SC_EXT    = 8'hE0;
    localparam logic [7:0] c_SC_BAT_OK = 8'hAA;
    localparam logic [7:0] c_SC_LSHIFT = 8'h12;
    localparam logic [7:0] c_SC_RSHIFT = 8'h59;
    localparam logic [7:0] c_SC_LCTRL  = 8'h14;
    localparam logic [7:0] c_SC_ENTER  = 8'h5A;
    localparam logic [7:0] c_SC_SPACE  = 8'h29;
    localparam logic [7:0] c_SC_BKSP   = 8'h66;
    localparam logic [7:0] c_SC_LEFT   = 8'h6B;
    localparam logic [7:0] c_SC_DOWN   = 8'h72;
    localparam logic [7:0] c_SC_UP     = 8'h75;
    localparam logic [7:0] c_SC_RIGHT  = 8'h74;

    // Position of one matrix bit
    typedef struct packed {
        logic       valid;
        logic [2:0] row;
        logic [2:0] col;
    } zx_key_t;

    function automatic zx_key_t zx_key(input logic [2:0] row, input logic [2:0] col);
        zx_key_t k;
        k.valid = 1'b1;
        k.row   = row;
        k.col   = col;
        return k;
    endfunction

    // Plain (un-prefixed) scan code -> single matrix position
    function automatic zx_key_t zx_lookup(input logic [7:0] code);
        zx_key_t k;
        k = '0;
        case (code)
            c_SC_LSHIFT, c_SC_RSHIFT: k = zx_key(c_ROW_A8, c_COL0);   // CAPS SHIFT
            8'h1A: k = zx_key(c_ROW_A8,  c_COL1);                     // Z
            8'h22: k = zx_key(c_ROW_A8,  c_COL2);                     // X
            8'h21: k = zx_key(c_ROW_A8,  c_COL3);                     // C
            8'h2A: k = zx_key(c_ROW_A8,  c_COL4);                     // V
            8'h1C: k = zx_key(c_ROW_A9,  c_COL0);                     // A
            8'h1B: k = zx_key(c_ROW_A9,  c_COL1);                     // S
            8'h23: k = zx_key(c_ROW_A9,  c_COL2);                     // D
            8'h2B: k = zx_key(c_ROW_A9,  c_COL3);                     // F
            8'h34: k = zx_key(c_ROW_A9,  c_COL4);                     // G
            8'h15: k = zx_key(c_ROW_A10, c_COL0);                     // Q
            8'h1D: k = zx_key(c_ROW_A10, c_COL1);                     // W
            8'h24: k = zx_key(c_ROW_A10, c_COL2);                     // E
            8'h2D: k = zx_key(c_ROW_A10, c_COL3);                     // R
            8'h2C: k = zx_key(c_ROW_A10, c_COL4);                     // T
            8'h16: k = zx_key(c_ROW_A11, c_COL0);                     // 1
            8'h1E: k = zx_key(c_ROW_A11, c_COL1);                     // 2
            8'h26: k = zx_key(c_ROW_A11, c_COL2);                     // 3
            8'h25: k = zx_key(c_ROW_A11, c_COL3);                     // 4
            8'h2E: k = zx_key(c_ROW_A11, c_COL4);                     // 5
            8'h45: k = zx_key(c_ROW_A12, c_COL0);                     // 0
            8'h46: k = zx_key(c_ROW_A12, c_COL1);                     // 9
            8'h3E: k = zx_key(c_ROW_A12, c_COL2);                     // 8
            8'h3D: k = zx_key(c_ROW_A12, c_COL3);                     // 7
            8'h36: k = zx_key(c_ROW_A12, c_COL4);                     // 6
            8'h4D: k = zx_key(c_ROW_A13, c_COL0);                     // P
            8'h44: k = zx_key(c_ROW_A13, c_COL1);                     // O
            8'h43: k = zx_key(c_ROW_A13, c_COL2);                     // I
            8'h3C: k = zx_key(c_ROW_A13, c_COL3);                     // U
            8'h35: k = zx_key(c_ROW_A13, c_COL4);                     // Y
            c_SC_ENTER: k = zx_key(c_ROW_A14, c_COL0);                // ENTER
            8'h4B: k = zx_key(c_ROW_A14, c_COL1);                     // L
            8'h42: k = zx_key(c_ROW_A14, c_COL2);                     // K
            8'h3B: k = zx_key(c_ROW_A14, c_COL3);                     // J
            8'h33: k = zx_key(c_ROW_A14, c_COL4);                     // H
            c_SC_SPACE: k = zx_key(c_ROW_A15, c_COL0);                // SPACE
            c_SC_LCTRL: k = zx_key(c_ROW_A15, c_COL1);                // SYMBOL SHIFT
            8'h3A: k = zx_key(c_ROW_A15, c_COL2);                     // M
            8'h31: k = zx_key(c_ROW_A15, c_COL3);                     // N
            8'h32: k = zx_key(c_ROW_A15, c_COL4);                     // B
            default: k = '0;
        endcase
        return k;
    endfunction

    // Composite keys (CAPS SHIFT + one other bit): returns the non-CS bit.
    // Cursor keys need the E0 prefix; backspace must arrive without it.
    function automatic zx_key_t zx_ext_lookup(input logic [7:0] code, input logic ext);
        zx_key_t k;
        k = '0;
        if (ext) begin
            case (code)
                c_SC_LEFT:  k = zx_key(c_ROW_A11, c_COL4);            // CS+5
                c_SC_DOWN:  k = zx_key(c_ROW_A12, c_COL4);            // CS+6
                c_SC_UP:    k = zx_key(c_ROW_A12, c_COL3);            // CS+7
                c_SC_RIGHT: k = zx_key(c_ROW_A12, c_COL2);            // CS+8
                default:    k = '0;
            endcase
        end else if (code == c_SC_BKSP) begin
            k = zx_key(c_ROW_A12, c_COL0);                            // CS+0
        end
        return k;
    endfunction

endpackage
`default_nettype wire

// File: rtl/zx_ps2_rx.sv
`default_nettype none
// ============================================================================
//  Module      : zx_ps2_rx
//  Description : PS/2 device->host byte receiver. Synchronises and
//                glitch-filters the pad clock, samples data on filtered
//                falling edges, checks odd parity and stop bit, and aborts
//                a stalled frame after TIMEOUT_CYC idle cycles.
//  Revision    : 1.0  initial release
// ============================================================================
module zx_ps2_rx #(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 27000
) (
    input  logic       clk,
    input  logic       i_rst_n,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_data,
    output logic [7:0] o_rx_byte,
    output logic       o_rx_valid,
    output logic       o_rx_err
);
    localparam int FW   = (FILTER_LEN > 2) ? $clog2(FILTER_LEN) : 1;
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_DATA   = 2'd1;
    localparam logic [1:0] c_ST_PARITY = 2'd2;
    localparam logic [1:0] c_ST_STOP   = 2'd3;

    logic [1:0]      r_clk_sync_q;
    logic [1:0]      r_dat_sync_q;
    logic [FW-1:0]   r_fcnt_q,   w_fcnt_d;
    logic            r_fclk_q,   w_fclk_d;
    logic [1:0]      r_state_q,  w_state_d;
    logic [2:0]      r_bitcnt_q, w_bitcnt_d;
    logic [7:0]      r_shift_q,  w_shift_d;
    logic            r_par_q,    w_par_d;
    logic [TO_W-1:0] r_to_q,     w_to_d;
    logic [7:0]      r_byte_q,   w_byte_d;
    logic            r_valid_q,  w_valid_d;
    logic            r_err_q,    w_err_d;
    logic            w_bit_edge;
    logic            w_data;

    // Two-flop synchronisers on the asynchronous pad inputs
    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            r_clk_sync_q <= 2'b11;
            r_dat_sync_q <= 2'b11;
        end else begin
            r_clk_sync_q <= {r_clk_sync_q[0], i_ps2_clk};
            r_dat_sync_q <= {r_dat_sync_q[0], i_ps2_data};
        end
    end

    assign w_data = r_dat_sync_q[1];

    // Filtered clock flips only after FILTER_LEN consecutive differing samples
    always_comb begin
        w_fcnt_d   = '0;
        w_fclk_d   = r_fclk_q;
        w_bit_edge = 1'b0;
        if (r_clk_sync_q[1] != r_fclk_q) begin
            if (r_fcnt_q == FW'(FILTER_LEN - 1)) begin
                w_fclk_d   = r_clk_sync_q[1];
                w_bit_edge = r_fclk_q;      // 1 -> 0 is a bit edge
            end else begin
                w_fcnt_d = r_fcnt_q + FW'(1);
            end
        end
    end

    // Frame FSM: start, 8 data bits LSB first, odd parity, stop, plus timeout
    always_comb begin
        w_state_d  = r_state_q;
        w_bitcnt_d = r_bitcnt_q;
        w_shift_d  = r_shift_q;
        w_par_d    = r_par_q;
        w_to_d     = r_to_q;
        w_byte_d   = r_byte_q;
        w_valid_d  = 1'b0;
        w_err_d    = 1'b0;
        if (w_bit_edge) begin
            w_to_d = '0;
            case (r_state_q)
                c_ST_IDLE: begin
                    if (!w_data) begin
                        w_state_d  = c_ST_DATA;
                        w_bitcnt_d = 3'd0;
                    end
                end
                c_ST_DATA: begin
                    w_shift_d  = {w_data, r_shift_q[7:1]};
                    w_bitcnt_d = r_bitcnt_q + 3'd1;
                    if (r_bitcnt_q == 3'd7) begin
                        w_state_d = c_ST_PARITY;
                    end
                end
                c_ST_PARITY: begin
                    w_par_d   = w_data;
                    w_state_d = c_ST_STOP;
                end
                default: begin
                    if (w_data && (^{r_shift_q, r_par_q})) begin
                        w_byte_d  = r_shift_q;
                        w_valid_d = 1'b1;
                    end else begin
                        w_err_d = 1'b1;
                    end
                    w_state_d = c_ST_IDLE;
                end
            endcase
        end else if (r_state_q != c_ST_IDLE) begin
            if (r_to_q == TO_W'(TIMEOUT_CYC - 1)) begin
                w_state_d = c_ST_IDLE;
                w_err_d   = 1'b1;
                w_to_d    = '0;
            end else begin
                w_to_d = r_to_q + TO_W'(1);
            end
        end
    end

    // Receiver state registers
    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            r_fcnt_q   <= '0;
            r_fclk_q   <= 1'b1;
            r_state_q  <= c_ST_IDLE;
            r_bitcnt_q <= 3'd0;
            r_shift_q  <= 8'h00;
            r_par_q    <= 1'b0;
            r_to_q     <= '0;
            r_byte_q   <= 8'h00;
            r_valid_q  <= 1'b0;
            r_err_q    <= 1'b0;
        end else begin
            r_fcnt_q   <= w_fcnt_d;
            r_fclk_q   <= w_fclk_d;
            r_state_q  <= w_state_d;
            r_bitcnt_q <= w_bitcnt_d;
            r_shift_q  <= w_shift_d;
            r_par_q    <= w_par_d;
            r_to_q     <= w_to_d;
            r_byte_q   <= w_byte_d;
            r_valid_q  <= w_valid_d;
            r_err_q    <= w_err_d;
        end
    end

    assign o_rx_byte  = r_byte_q;
    assign o_rx_valid = r_valid_q;
    assign o_rx_err   = r_err_q;

endmodule
`default_nettype wire

// File: rtl/zx_ps2_keymatrix.sv
`default_nettype none
// ============================================================================
//  Module      : zx_ps2_keymatrix
//  Description : PS/2 keyboard front end for the port-FE read path. Decodes
//                set-2 scan codes into the 8x5 active-low ZX Spectrum key
//                matrix and returns the column bits of the rows selected by
//                A15..A8 with zero latency.
//  Options     : ZX_KBD_EXT_KEYS_EN - E0 cursor keys and backspace drive
//                CAPS SHIFT plus a second key.
//  Revision    : 1.0  initial release
// ============================================================================
module zx_ps2_keymatrix
    import zx_kbd_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 27000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic [7:0] addr_hi,
    output logic [4:0] keys_n,
    output logic [7:0] scan_code,
    output logic       scan_strobe,
    output logic       frame_err
);
    logic [7:0] w_rx_byte;
    logic       w_rx_valid;
    logic       w_rx_err;

    logic [c_NUM_ROWS-1:0][c_NUM_COLS-1:0] r_matrix_q, w_matrix_d;
    logic       r_brk_q,    w_brk_d;
    logic       r_ext_q,    w_ext_d;
    logic [7:0] r_code_q,   w_code_d;
    logic       r_strobe_q, w_strobe_d;
    logic       r_err_q,    w_err_d;
    zx_key_t    w_key;
    logic [4:0] w_keys;

    zx_ps2_rx #(
        .FILTER_LEN  (FILTER_LEN),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_rx (
        .clk        (clk),
        .i_rst_n    (reset),
        .i_ps2_clk  (ps2_clk),
        .i_ps2_data (ps2_data),
        .o_rx_byte  (w_rx_byte),
        .o_rx_valid (w_rx_valid),
        .o_rx_err   (w_rx_err)
    );

`ifdef ZX_KBD_EXT_KEYS_EN
    zx_key_t w_ext_key;
    assign w_ext_key = zx_ext_lookup(w_rx_byte, r_ext_q);
`endif

    assign w_key = zx_lookup(w_rx_byte);

    // Scan-code decoder: prefix flags and matrix updates for each valid byte
    always_comb begin
        w_matrix_d = r_matrix_q;
        w_brk_d    = r_brk_q;
        w_ext_d    = r_ext_q;
        w_code_d   = r_code_q;
        w_strobe_d = w_rx_valid;
        w_err_d    = w_rx_err;
        if (w_rx_valid) begin
            w_code_d = w_rx_byte;
            if (w_rx_byte == c_SC_BREAK) begin
                w_brk_d = 1'b1;
            end else if (w_rx_byte == c_SC_EXT) begin
                w_ext_d = 1'b1;
            end else begin
                w_brk_d = 1'b0;
                w_ext_d = 1'b0;
                if (w_rx_byte == c_SC_BAT_OK) begin
                    w_matrix_d = '1;
`ifdef ZX_KBD_EXT_KEYS_EN
                end else if (w_ext_key.valid) begin
                    // Composite key: CAPS SHIFT and the second bit move together
                    w_matrix_d[c_ROW_A8][c_COL0]             = r_brk_q;
                    w_matrix_d[w_ext_key.row][w_ext_key.col] = r_brk_q;
`endif
                end else if (!r_ext_q && w_key.valid) begin
                    w_matrix_d[w_key.row][w_key.col] = r_brk_q;
                end
            end
        end
    end

    // Matrix, flags and byte/pulse outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_matrix_q <= '1;
            r_brk_q    <= 1'b0;
            r_ext_q    <= 1'b0;
            r_code_q   <= 8'h00;
            r_strobe_q <= 1'b0;
            r_err_q    <= 1'b0;
        end else begin
            r_matrix_q <= w_matrix_d;
            r_brk_q    <= w_brk_d;
            r_ext_q    <= w_ext_d;
            r_code_q   <= w_code_d;
            r_strobe_q <= w_strobe_d;
            r_err_q    <= w_err_d;
        end
    end

    // Readout: AND together every row whose address line is low
    always_comb begin
        w_keys = 5'h1F;
        for (int r = 0; r < c_NUM_ROWS; r++) begin
            if (!addr_hi[r]) begin
                w_keys = w_keys & r_matrix_q[r];
            end
        end
    end

    assign keys_n      = w_keys;
    assign scan_code   = r_code_q;
    assign scan_strobe = r_strobe_q;
    assign frame_err   = r_err_q;

endmodule
`default_nettype wire

// File: tb/tb_zx_ps2_keymatrix.sv
`default_nettype none
// ============================================================================
//  Module      : tb_zx_ps2_keymatrix
//  Description : Directed bench for zx_ps2_keymatrix. Expected receiver
//                events are queued as frames are sent and checked by an
//                independent monitor; key readouts are checked directly.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_zx_ps2_keymatrix;

    localparam int HALF        = 20;      // clk cycles per PS/2 half period
    localparam int TIMEOUT_CYC = 27000;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] addr_hi = 8'hFF;
    logic [4:0] keys_n;
    logic [7:0] scan_code;
    logic       scan_strobe;
    logic       frame_err;

    int errors = 0;
    int checks = 0;

    typedef struct {
        bit         is_err;
        logic [7:0] code;
    } exp_t;

    exp_t exp_q[$];

    zx_ps2_keymatrix #(
        .FILTER_LEN  (8),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .ps2_clk     (ps2_clk),
        .ps2_data    (ps2_data),
        .addr_hi     (addr_hi),
        .keys_n      (keys_n),
        .scan_code   (scan_code),
        .scan_strobe (scan_strobe),
        .frame_err   (frame_err)
    );

    always #5 clk = ~clk;

    // Monitor: every strobe or error pulse must match the head of the queue
    always @(negedge clk) begin
        if (reset && (scan_strobe || frame_err)) begin
            exp_t e;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event strobe=%0b err=%0b code=%h (none expected)",
                         scan_strobe, frame_err, scan_code);
            end else begin
                e = exp_q.pop_front();
                if (e.is_err) begin
                    if (!frame_err || scan_strobe) begin
                        errors++;
                        $display("FAIL frame_err_event got strobe=%0b err=%0b, required err=1 strobe=0",
                                 scan_strobe, frame_err);
                    end
                end else if (!scan_strobe || frame_err || scan_code !== e.code) begin
                    errors++;
                    $display("FAIL byte_event got strobe=%0b err=%0b code=%h, required strobe=1 code=%h",
                             scan_strobe, frame_err, scan_code, e.code);
                end
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic send_bit(input logic b);
        ps2_data = b;
        wait_cyc(HALF);
        ps2_clk = 1'b0;
        wait_cyc(HALF);
        ps2_clk = 1'b1;
    endtask

    // Full 11-bit frame; the expected event is queued before sending
    task automatic send_frame(input logic [7:0] b, input bit bad_par);
        exp_t e;
        logic par;
        par = ~(^b) ^ bad_par;
        e.is_err = bad_par;
        e.code   = b;
        exp_q.push_back(e);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(par);
        send_bit(1'b1);
        wait_cyc(HALF);
    endtask

    // First n bits of a frame (start bit first), line left idle-high
    task automatic send_partial(input logic [7:0] b, input int n);
        send_bit(1'b0);
        for (int i = 0; i < n - 1; i++) send_bit(b[i]);
        ps2_data = 1'b1;
    endtask

    // Bounded wait for the monitor to consume all queued events
    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s pending=%0d events after %0d cycles, required 0", name, exp_q.size(), budget);
            exp_q.delete();
        end
    endtask

    task automatic check_keys(input string name, input logic [7:0] addr, input logic [4:0] exp);
        addr_hi = addr;
        @(negedge clk);
        checks++;
        if (keys_n !== exp) begin
            errors++;
            $display("FAIL %s addr_hi=%h keys_n=%h required %h", name, addr, keys_n, exp);
        end
    endtask

    task automatic check_val(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h required %h", name, act, exp);
        end
    endtask

    initial begin
        wait_cyc(4);
        @(negedge clk);
        check_val("reset_scan_code", scan_code, 8'h00);
        check_val("reset_strobe", {7'd0, scan_strobe}, 8'h00);
        check_val("reset_err", {7'd0, frame_err}, 8'h00);
        check_keys("reset_all_rows", 8'h00, 5'h1F);
        reset = 1'b1;
        wait_cyc(4);

        // ENTER press and release
        send_frame(8'h5A, 1'b0);
        drain("drain_enter", 200);
        check_keys("enter_pressed", 8'hBF, 5'h1E);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h5A, 1'b0);
        drain("drain_enter_rel", 200);
        check_keys("enter_released", 8'hBF, 5'h1F);

        // CAPS SHIFT + Z, multi-row select
        send_frame(8'h12, 1'b0);
        send_frame(8'h1A, 1'b0);
        drain("drain_cs_z", 200);
        check_keys("cs_z_row0", 8'hFE, 5'h1C);
        check_keys("cs_z_all_rows", 8'h00, 5'h1C);
        check_keys("cs_z_no_rows", 8'hFF, 5'h1F);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h12, 1'b0);
        drain("drain_cs_rel", 200);
        check_keys("cs_released", 8'hFE, 5'h1D);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h1A, 1'b0);
        drain("drain_z_rel", 200);

        // Parity error: discarded, matrix untouched
        send_frame(8'h5A, 1'b1);
        drain("drain_parity", 200);
        check_keys("parity_no_change", 8'hBF, 5'h1F);

        // Stalled frame times out, then a clean frame is accepted
        begin
            exp_t e;
            e.is_err = 1'b1;
            e.code   = 8'h00;
            exp_q.push_back(e);
        end
        send_partial(8'h29, 5);
        wait_cyc(TIMEOUT_CYC + 10);
        drain("drain_timeout", 200);
        send_frame(8'h29, 1'b0);
        drain("drain_space", 200);
        check_keys("space_pressed", 8'h7F, 5'h1E);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h29, 1'b0);
        drain("drain_space_rel", 200);

        // BAT-OK clears everything
        send_frame(8'h1C, 1'b0);
        drain("drain_a", 200);
        check_keys("a_pressed", 8'hFD, 5'h1E);
        send_frame(8'hAA, 1'b0);
        drain("drain_bat", 200);
        check_keys("bat_clears", 8'h00, 5'h1F);

        // Reset mid-frame clears matrix and outputs; next frame decodes
        send_frame(8'h1C, 1'b0);
        drain("drain_a2", 200);
        check_keys("a_pressed2", 8'hFD, 5'h1E);
        send_partial(8'h5A, 5);
        reset = 1'b0;
        wait_cyc(3);
        @(negedge clk);
        check_val("midreset_scan_code", scan_code, 8'h00);
        reset = 1'b1;
        check_keys("midreset_matrix", 8'h00, 5'h1F);
        wait_cyc(4);
        send_frame(8'h1C, 1'b0);
        drain("drain_after_reset", 200);
        check_keys("a_after_reset", 8'hFD, 5'h1E);
        send_frame(8'hAA, 1'b0);
        drain("drain_bat2", 200);

        // Extended cursor-up
        send_frame(8'hE0, 1'b0);
        send_frame(8'h75, 1'b0);
        drain("drain_up", 200);
`ifdef ZX_KBD_EXT_KEYS_EN
        check_keys("up_row4", 8'hEF, 5'h17);
        check_keys("up_row0", 8'hFE, 5'h1E);
`else
        check_keys("up_ignored", 8'h00, 5'h1F);
`endif

        wait_cyc(20);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
